// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio delay-line controller.
package audio_pkg;

    localparam int DEPTH = 3072;
    localparam int AW    = 12;
    localparam int DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

endpackage

// File: rtl/ring_addr.sv
// Modulo-DEPTH pointer arithmetic for the delay ring: write-pointer increment
// and the delayed read address.
module ring_addr #(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic [AW-1:0] wr_ptr,
    input  logic [AW-1:0] delay,
    output logic [AW-1:0] wr_next,
    output logic [AW-1:0] rd_addr
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    always_comb begin
        wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        // The wrapped result is below DEPTH, so modulo-2^AW arithmetic is exact.
        rd_addr = (wr_ptr >= delay) ? wr_ptr - delay : wr_ptr - delay + DEPTH_A;
    end

endmodule

// File: rtl/audio_delay_ctrl.sv
// Ring-buffer controller turning an external dual-port RAM into a programmable
// audio delay line, with mute until the buffer holds the requested delay.
module audio_delay_ctrl #(
    parameter int DEPTH = audio_pkg::DEPTH,
    parameter int AW    = audio_pkg::AW,
    parameter int DW    = audio_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_ch,
    output logic          in_ready,
    input  logic [AW-1:0] cfg_delay,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_ch,
    input  logic          out_ready,
    output logic          overrun,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_dina,
    output logic          ram_cea,
    output logic          ram_wrea,
    output logic [AW-1:0] ram_adb,
    output logic          ram_ceb,
    output logic          ram_wreb,
    input  logic [DW-1:0] ram_doutb
);

    import audio_pkg::*;

    localparam logic [AW-1:0] MAX_D = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill_cnt;
    logic [AW-1:0] delay_q;
    logic          unmute_q;

    logic [AW-1:0] d_eff;
    logic [AW-1:0] fill_eff;
    logic          d_change;
    logic          accept;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] rd_addr;

    always_comb begin
        d_eff    = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;
        d_change = (d_eff != delay_q);
        // A delay change restarts the fill, so the mute decision must see zero.
        fill_eff = d_change ? '0 : fill_cnt;
        accept   = (state_q == ST_IDLE) && in_valid;
    end

    ring_addr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring_addr (
        .wr_ptr  (wr_ptr),
        .delay   (d_eff),
        .wr_next (wr_next),
        .rd_addr (rd_addr)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);

    assign ram_cea   = accept;
    assign ram_wrea  = accept;
    assign ram_ada   = wr_ptr;
    assign ram_dina  = in_data;
    assign ram_ceb   = accept && (d_eff != '0);
    assign ram_adb   = rd_addr;
    assign ram_wreb  = 1'b0;

    // NOTE: the RAM is outside and never cleared; fill_cnt-based mute hides stale words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            delay_q  <= '0;
            unmute_q <= 1'b0;
            out_data <= '0;
            out_ch   <= CH_L;
            overrun  <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (d_change) begin
                        delay_q  <= d_eff;
                        fill_cnt <= '0;
                    end
                    if (in_valid) begin
                        wr_ptr   <= wr_next;
                        fill_cnt <= (fill_eff == MAX_D) ? fill_eff : fill_eff + AW'(1);
                        unmute_q <= (fill_eff >= d_eff);
                        out_ch   <= in_ch;
                        if (d_eff == '0) begin
                            out_data <= in_data;
                            state_q  <= ST_OUT;
                        end else begin
                            state_q  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    out_data <= unmute_q ? ram_doutb : '0;
                    state_q  <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
